spi_regbank: RTL

SPI_REGBANK -- requirements
Module: spi_regbank

---
 rtl/spi_regbank_pkg.sv | 33 +++
 rtl/spi_regbank_irq.sv | 49 ++++
 rtl/spi_regbank.sv | 115 +++++++++++
 3 files changed

// File: rtl/spi_regbank_pkg.sv
// Shared address-map offsets, access classification and decode helper for the
// SPI register bank.
package spi_regbank_pkg;

  // CFG_BASE is absolute. The other offsets are relative to the end of the
  // preceding window, so the map works for any NUM_CFG/NUM_STATUS.
  localparam int CFG_BASE     = 0;
  localparam int STATUS_BASE  = 0;
  localparam int IRQ_PEND_OFS = 0;
  localparam int IRQ_MASK_OFS = 1;

  typedef enum logic [2:0] {
    ACC_CFG,
    ACC_STATUS,
    ACC_PEND,
    ACC_MASK,
    ACC_UNMAPPED
  } access_t;

  function automatic access_t decode_addr(input int addr, input int num_cfg,
                                          input int num_status);
    int status_lo;
    int irq_lo;
    status_lo = CFG_BASE + num_cfg + STATUS_BASE;
    irq_lo    = status_lo + num_status;
    if (addr < CFG_BASE + num_cfg)          return ACC_CFG;
    else if (addr < irq_lo)                 return ACC_STATUS;
    else if (addr == irq_lo + IRQ_PEND_OFS) return ACC_PEND;
    else if (addr == irq_lo + IRQ_MASK_OFS) return ACC_MASK;
    else                                    return ACC_UNMAPPED;
  endfunction

endpackage

// File: rtl/spi_regbank_irq.sv
// Status sampling, per-register change detection and the sticky IRQ pending
// bits (write-1-to-clear, set has priority over clear).
module spi_regbank_irq
  import spi_regbank_pkg::*;
#(
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            ena,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  input  logic [NUM_STATUS-1:0]           clr,
  output logic [NUM_STATUS*REG_WIDTH-1:0] sample,
  output logic [NUM_STATUS-1:0]           pend
);

  logic [NUM_STATUS*REG_WIDTH-1:0] sample_q;
  logic [NUM_STATUS*REG_WIDTH-1:0] prev_q;
  logic                            primed;
  logic [NUM_STATUS-1:0]           pend_q;
  logic [NUM_STATUS-1:0]           chg;

  always_comb begin
    chg = '0;
    for (int i = 0; i < NUM_STATUS; i++) begin
      chg[i] = sample_q[i*REG_WIDTH +: REG_WIDTH] != prev_q[i*REG_WIDTH +: REG_WIDTH];
    end
  end

  // The first sample after reset also seeds prev, so it never reads as a change.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sample_q <= '0;
      prev_q   <= '0;
      primed   <= 1'b0;
      pend_q   <= '0;
    end else if (ena) begin
      sample_q <= status_regs;
      prev_q   <= primed ? sample_q : status_regs;
      primed   <= 1'b1;
      pend_q   <= (pend_q & ~clr) | chg;
    end
  end

  assign sample = sample_q;
  assign pend   = pend_q;

endmodule

// File: rtl/spi_regbank.sv
// Host-accessible register bank: read/write CFG registers, sampled read-only
// STATUS registers, and a masked change interrupt with pending/mask registers.
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            ena,
  input  logic                            req_valid,
  input  logic                            req_wr,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [REG_WIDTH-1:0]            req_wdata,
  output logic                            rsp_valid,
  output logic [REG_WIDTH-1:0]            rsp_rdata,
  output logic                            rsp_err,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic                            irq
);

  localparam int STATUS_LO = CFG_BASE + NUM_CFG + STATUS_BASE;

  if ((1 << ADDR_WIDTH) < NUM_CFG + NUM_STATUS + 2) begin : g_addr_chk
    $error("spi_regbank: ADDR_WIDTH too small for the register map");
  end
  if (NUM_STATUS > REG_WIDTH) begin : g_status_chk
    $error("spi_regbank: NUM_STATUS must not exceed REG_WIDTH");
  end

  logic                            accept;
  access_t                         acc;
  logic [NUM_CFG*REG_WIDTH-1:0]    cfg_q;
  logic [NUM_STATUS-1:0]           mask_q;
  logic [NUM_STATUS-1:0]           pend;
  logic [NUM_STATUS-1:0]           clr;
  logic [NUM_STATUS*REG_WIDTH-1:0] sample;
  logic [REG_WIDTH-1:0]            rdata_d;
  logic                            err_d;

  assign accept = req_valid & ena;
  assign acc    = decode_addr(int'(req_addr), NUM_CFG, NUM_STATUS);
  assign clr    = (accept && req_wr && acc == ACC_PEND) ? req_wdata[NUM_STATUS-1:0] : '0;

  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    case (acc)
      ACC_CFG: begin
        for (int k = 0; k < NUM_CFG; k++) begin
          if (req_addr == ADDR_WIDTH'(CFG_BASE + k)) rdata_d = cfg_q[k*REG_WIDTH +: REG_WIDTH];
        end
      end
      ACC_STATUS: begin
        err_d = req_wr;
        for (int k = 0; k < NUM_STATUS; k++) begin
          if (req_addr == ADDR_WIDTH'(STATUS_LO + k)) rdata_d = sample[k*REG_WIDTH +: REG_WIDTH];
        end
      end
      ACC_PEND: rdata_d = REG_WIDTH'(pend);
      ACC_MASK: rdata_d = REG_WIDTH'(mask_q);
      default:  err_d   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cfg_q  <= '0;
      mask_q <= '0;
    end else if (accept && req_wr) begin
      if (acc == ACC_CFG) begin
        for (int k = 0; k < NUM_CFG; k++) begin
          if (req_addr == ADDR_WIDTH'(CFG_BASE + k)) cfg_q[k*REG_WIDTH +: REG_WIDTH] <= req_wdata;
        end
      end
      if (acc == ACC_MASK) mask_q <= req_wdata[NUM_STATUS-1:0];
    end
  end

  // Write responses carry rdata 0; the response path ignores ena so an
  // access accepted just before ena drops still completes.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_rdata <= (accept && !req_wr) ? rdata_d : '0;
      rsp_err   <= accept ? err_d : 1'b0;
      if (ena) irq <= |(pend & mask_q);
    end
  end

  spi_regbank_irq #(
    .NUM_STATUS (NUM_STATUS),
    .REG_WIDTH  (REG_WIDTH)
  ) u_irq (
    .clk         (clk),
    .rstb        (rstb),
    .ena         (ena),
    .status_regs (status_regs),
    .clr         (clr),
    .sample      (sample),
    .pend        (pend)
  );

  assign config_regs = cfg_q;

endmodule
